// File: rtl/blend_scheduler.sv
// -----------------------------------------------------------------------------
// blend_scheduler
//
// Front end of the alpha-blend datapath. Rasterizer fragments (address + RGBA
// + end-of-frame flag) are accepted over a valid/ready handshake into a small
// FIFO. One fragment per cycle is issued to the blender as a registered
// blend_pixel_ready strobe with registered address/colour. An in-order
// scoreboard of in-flight addresses blocks a fragment whose pixel is still in
// the blender's read-modify-write pipe. frame_ready pulses once the final
// fragment of a frame has retired.
//
// Ports
//   clk, reset                 clock, asynchronous active-low reset
//   in_valid / in_ready        fragment handshake from rasterizer
//   in_pixel_number, in_r/g/b/a, in_last   fragment payload
//   blend_pixel_ready          one-cycle issue strobe to blender
//   blend_pixel_number, blend_r/g/b/a      issued fragment (held between issues)
//   blend_write, blend_pixel_number_o      in-order retire from blender
//   frame_ready                one-cycle pulse: whole frame retired
//   busy                       frame in progress (FSM not idle)
//   order_error                sticky: retire did not match oldest in-flight
// -----------------------------------------------------------------------------
module blend_scheduler #(
   parameter int DEPTH        = 4,
   parameter int MAX_INFLIGHT = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [16:0] in_pixel_number,
   input  logic [7:0]  in_r,
   input  logic [7:0]  in_g,
   input  logic [7:0]  in_b,
   input  logic [7:0]  in_a,
   input  logic        in_last,
   output logic        blend_pixel_ready,
   output logic [16:0] blend_pixel_number,
   output logic [7:0]  blend_r,
   output logic [7:0]  blend_g,
   output logic [7:0]  blend_b,
   output logic [7:0]  blend_a,
   input  logic        blend_write,
   input  logic [16:0] blend_pixel_number_o,
   output logic        frame_ready,
   output logic        busy,
   output logic        order_error
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int SW = $clog2(MAX_INFLIGHT + 1);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

   typedef struct packed {
      logic [16:0] addr;
      logic [7:0]  r;
      logic [7:0]  g;
      logic [7:0]  b;
      logic [7:0]  a;
      logic        last;
   } frag_t;

   state_t         state_q, state_d;
   frag_t          fifo_mem_q [DEPTH];
   frag_t          in_frag;
   logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]  fifo_cnt_q, fifo_cnt_d;
   logic [16:0]    sb_addr_q [MAX_INFLIGHT];
   logic [16:0]    sb_addr_d [MAX_INFLIGHT];
   logic [SW-1:0]  sb_cnt_q, sb_cnt_d;
   logic [SW-1:0]  sb_wr_idx;

   logic           bpr_q, bpr_d;
   logic [16:0]    bpn_q, bpn_d;
   logic [7:0]     br_q, br_d, bg_q, bg_d, bb_q, bb_d, ba_q, ba_d;
   logic           frame_ready_q, frame_ready_d;
   logic           busy_q, busy_d;
   logic           order_error_q, order_error_d;

   logic           fifo_empty, fifo_full, accept_ok;
   logic           push, issue, hazard, retire, bad_retire;
   logic [16:0]    head_addr;

   always_comb begin
      in_frag = '{addr: in_pixel_number, r: in_r, g: in_g, b: in_b, a: in_a, last: in_last};
   end

   // Handshake, hazard check and issue decision, all on pre-edge state
   always_comb begin
      fifo_empty = (fifo_cnt_q == '0);
      fifo_full  = (fifo_cnt_q == CW'(DEPTH));
      accept_ok  = !fifo_full && (state_q == IDLE || state_q == RUN);
      // Gated by the reset pin so in_ready reads 0 while reset is held.
      in_ready   = reset && accept_ok;
      push       = in_valid && in_ready;
      head_addr  = fifo_mem_q[rd_ptr_q].addr;

      // Compare against pre-retire contents: an entry retiring this cycle
      // still blocks its address for one more cycle.
      hazard = 1'b0;
      for (int i = 0; i < MAX_INFLIGHT; i++) begin
         if (SW'(i) < sb_cnt_q && sb_addr_q[i] == head_addr) hazard = 1'b1;
      end

      issue      = !fifo_empty && (sb_cnt_q < SW'(MAX_INFLIGHT)) && !hazard;
      retire     = blend_write && (sb_cnt_q != '0);
      bad_retire = blend_write && ((sb_cnt_q == '0) || (blend_pixel_number_o != sb_addr_q[0]));
   end

   // FIFO pointers / occupancy
   always_comb begin
      wr_ptr_d = push  ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = issue ? rd_ptr_q + PW'(1) : rd_ptr_q;
      case ({push, issue})
         2'b10:   fifo_cnt_d = fifo_cnt_q + CW'(1);
         2'b01:   fifo_cnt_d = fifo_cnt_q - CW'(1);
         default: fifo_cnt_d = fifo_cnt_q;
      endcase
   end

   // Scoreboard: entry 0 is the oldest; retire shifts down, issue appends
   always_comb begin
      sb_addr_d = sb_addr_q;
      if (retire) begin
         for (int i = 0; i < MAX_INFLIGHT - 1; i++) sb_addr_d[i] = sb_addr_q[i + 1];
      end
      sb_wr_idx = sb_cnt_q - SW'(retire);
      if (issue) begin
         for (int i = 0; i < MAX_INFLIGHT; i++) begin
            if (SW'(i) == sb_wr_idx) sb_addr_d[i] = head_addr;
         end
      end
      case ({issue, retire})
         2'b10:   sb_cnt_d = sb_cnt_q + SW'(1);
         2'b01:   sb_cnt_d = sb_cnt_q - SW'(1);
         default: sb_cnt_d = sb_cnt_q;
      endcase
   end

   // Frame FSM and registered outputs
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (push) state_d = in_last ? DRAIN : RUN;
         RUN:     if (push && in_last) state_d = DRAIN;
         // Uses post-edge occupancy so the edge sampling the final retire exits.
         DRAIN:   if (fifo_cnt_d == '0 && sb_cnt_d == '0) state_d = DONE;
         default: state_d = IDLE;
      endcase

      frame_ready_d = (state_q == DRAIN) && (state_d == DONE);
      busy_d        = (state_d != IDLE);
      order_error_d = order_error_q | bad_retire;

      bpr_d = issue;
      bpn_d = issue ? head_addr : bpn_q;
      br_d  = issue ? fifo_mem_q[rd_ptr_q].r : br_q;
      bg_d  = issue ? fifo_mem_q[rd_ptr_q].g : bg_q;
      bb_d  = issue ? fifo_mem_q[rd_ptr_q].b : bb_q;
      ba_d  = issue ? fifo_mem_q[rd_ptr_q].a : ba_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         fifo_cnt_q    <= '0;
         sb_cnt_q      <= '0;
         bpr_q         <= 1'b0;
         bpn_q         <= '0;
         br_q          <= '0;
         bg_q          <= '0;
         bb_q          <= '0;
         ba_q          <= '0;
         frame_ready_q <= 1'b0;
         busy_q        <= 1'b0;
         order_error_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         fifo_cnt_q    <= fifo_cnt_d;
         sb_cnt_q      <= sb_cnt_d;
         bpr_q         <= bpr_d;
         bpn_q         <= bpn_d;
         br_q          <= br_d;
         bg_q          <= bg_d;
         bb_q          <= bb_d;
         ba_q          <= ba_d;
         frame_ready_q <= frame_ready_d;
         busy_q        <= busy_d;
         order_error_q <= order_error_d;
      end
   end

   // Storage only; validity is tracked by the reset counters/pointers above
   always_ff @(posedge clk) begin
      if (push) fifo_mem_q[wr_ptr_q] <= in_frag;
      sb_addr_q <= sb_addr_d;
   end

   assign blend_pixel_ready  = bpr_q;
   assign blend_pixel_number = bpn_q;
   assign blend_r            = br_q;
   assign blend_g            = bg_q;
   assign blend_b            = bb_q;
   assign blend_a            = ba_q;
   assign frame_ready        = frame_ready_q;
   assign busy               = busy_q;
   assign order_error        = order_error_q;

endmodule

// File: tb/tb_blend_scheduler.sv
module tb_blend_scheduler;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [16:0] in_pixel_number;
   logic [7:0]  in_r, in_g, in_b, in_a;
   logic        in_last;
   logic        blend_pixel_ready;
   logic [16:0] blend_pixel_number;
   logic [7:0]  blend_r, blend_g, blend_b, blend_a;
   logic        blend_write;
   logic [16:0] blend_pixel_number_o;
   logic        frame_ready;
   logic        busy;
   logic        order_error;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   blend_scheduler #(.DEPTH(4), .MAX_INFLIGHT(2)) dut (
      .clk                  (clk),
      .reset                (reset),
      .in_valid             (in_valid),
      .in_ready             (in_ready),
      .in_pixel_number      (in_pixel_number),
      .in_r                 (in_r),
      .in_g                 (in_g),
      .in_b                 (in_b),
      .in_a                 (in_a),
      .in_last              (in_last),
      .blend_pixel_ready    (blend_pixel_ready),
      .blend_pixel_number   (blend_pixel_number),
      .blend_r              (blend_r),
      .blend_g              (blend_g),
      .blend_b              (blend_b),
      .blend_a              (blend_a),
      .blend_write          (blend_write),
      .blend_pixel_number_o (blend_pixel_number_o),
      .frame_ready          (frame_ready),
      .busy                 (busy),
      .order_error          (order_error)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic frag(input logic [16:0] addr, input logic [7:0] r, input logic [7:0] g,
                       input logic [7:0] b, input logic [7:0] a, input logic last);
      in_valid = 1'b1; in_pixel_number = addr;
      in_r = r; in_g = g; in_b = b; in_a = a; in_last = last;
   endtask

   task automatic retire(input logic [16:0] addr);
      blend_write = 1'b1; blend_pixel_number_o = addr;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_in_ready"}, in_ready, 0);
      chk({tag, "_bpr"}, blend_pixel_ready, 0);
      chk({tag, "_bpn"}, blend_pixel_number, 0);
      chk({tag, "_rgba"}, {blend_r, blend_g, blend_b, blend_a}, 0);
      chk({tag, "_frame_ready"}, frame_ready, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_order_error"}, order_error, 0);
   endtask

   int acc;
   int iss;
   logic rdy;

   initial begin
      reset = 1'b0; in_valid = 1'b0; in_pixel_number = '0;
      in_r = '0; in_g = '0; in_b = '0; in_a = '0; in_last = 1'b0;
      blend_write = 1'b0; blend_pixel_number_o = '0;

      // ---- reset ----
      tick();
      check_all_zero("rst");
      tick();
      reset = 1'b1;
      #1;
      chk("rst_rel_in_ready", in_ready, 1);
      chk("rst_rel_busy", busy, 0);

      // ---- single-fragment frame ----
      frag(17'd5, 8'h80, 8'h40, 8'hC0, 8'h11, 1'b1);
      tick();
      in_valid = 1'b0;
      chk("single_no_bypass", blend_pixel_ready, 0);
      chk("single_busy", busy, 1);
      tick();
      chk("single_bpr", blend_pixel_ready, 1);
      chk("single_bpn", blend_pixel_number, 5);
      chk("single_rgba", {blend_r, blend_g, blend_b, blend_a}, 32'h8040C011);
      tick();
      chk("single_bpr_pulse", blend_pixel_ready, 0);
      chk("single_hold", {blend_r, blend_g, blend_b, blend_a}, 32'h8040C011);
      retire(17'd5);
      tick();
      blend_write = 1'b0;
      chk("single_frame_ready", frame_ready, 1);
      chk("single_no_err", order_error, 0);
      tick();
      chk("single_frame_ready_off", frame_ready, 0);
      chk("single_idle", busy, 0);

      // ---- RAW hazard: 7, 7, 8 ----
      frag(17'd7, 8'h01, 8'h02, 8'h03, 8'h04, 1'b0);
      tick();
      frag(17'd7, 8'h05, 8'h06, 8'h07, 8'h08, 1'b0);
      tick();
      chk("raw_first_bpr", blend_pixel_ready, 1);
      chk("raw_first_bpn", blend_pixel_number, 7);
      chk("raw_first_r", blend_r, 8'h01);
      frag(17'd8, 8'h09, 8'h0A, 8'h0B, 8'h0C, 1'b1);
      tick();
      in_valid = 1'b0;
      chk("raw_stall_a", blend_pixel_ready, 0);
      tick();
      chk("raw_stall_b", blend_pixel_ready, 0);
      retire(17'd7);
      tick();
      blend_write = 1'b0;
      chk("raw_stall_retire_cycle", blend_pixel_ready, 0);
      tick();
      chk("raw_second_bpr", blend_pixel_ready, 1);
      chk("raw_second_bpn", blend_pixel_number, 7);
      chk("raw_second_r", blend_r, 8'h05);
      tick();
      chk("raw_third_bpr", blend_pixel_ready, 1);
      chk("raw_third_bpn", blend_pixel_number, 8);
      chk("raw_third_rgba", {blend_r, blend_g, blend_b, blend_a}, 32'h090A0B0C);
      retire(17'd7);
      tick();
      chk("raw_no_early_done", frame_ready, 0);
      retire(17'd8);
      tick();
      blend_write = 1'b0;
      chk("raw_frame_ready", frame_ready, 1);
      chk("raw_no_err", order_error, 0);
      tick();
      chk("raw_idle", busy, 0);

      // ---- full / backpressure ----
      acc = 0;
      iss = 0;
      for (int c = 0; c < 10; c++) begin
         frag(17'(10 + acc), 8'(acc), 8'h00, 8'h00, 8'h00, 1'b0);
         rdy = in_ready;
         tick();
         if (rdy) acc++;
         if (blend_pixel_ready) iss++;
      end
      chk("full_accepted", acc, 6);
      chk("full_issued", iss, 2);
      chk("full_in_ready", in_ready, 0);
      frag(17'd16, 8'h06, 8'h00, 8'h00, 8'h00, 1'b0);
      retire(17'd10);
      tick();
      blend_write = 1'b0;
      chk("full_retire_no_issue", blend_pixel_ready, 0);
      chk("full_retire_in_ready", in_ready, 0);
      tick();
      chk("full_third_issue", blend_pixel_ready, 1);
      chk("full_third_bpn", blend_pixel_number, 12);
      chk("full_slot_free", in_ready, 1);
      tick();
      in_valid = 1'b0;
      chk("full_refilled", in_ready, 0);
      chk("full_no_err", order_error, 0);

      // ---- reset with a full pipe ----
      reset = 1'b0;
      #1;
      check_all_zero("rst2");
      tick();
      tick();
      reset = 1'b1;
      #1;
      chk("rst2_in_ready", in_ready, 1);

      // ---- order error: wrong address ----
      frag(17'd3, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 1'b1);
      tick();
      in_valid = 1'b0;
      tick();
      chk("oe_issue_bpn", blend_pixel_number, 3);
      chk("oe_before", order_error, 0);
      retire(17'd4);
      tick();
      blend_write = 1'b0;
      chk("oe_set", order_error, 1);
      tick();
      tick();
      chk("oe_sticky", order_error, 1);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      #1;
      chk("oe_cleared", order_error, 0);

      // ---- order error: retire with empty scoreboard ----
      retire(17'd0);
      tick();
      blend_write = 1'b0;
      chk("oe_empty_sb", order_error, 1);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      #1;

      // ---- reset mid-frame: 3 queued, 2 in flight ----
      for (int k = 0; k < 5; k++) begin
         frag(17'(20 + k), 8'(k), 8'h00, 8'h00, 8'h00, 1'b0);
         tick();
      end
      in_valid = 1'b0;
      chk("mid_busy", busy, 1);
      chk("mid_in_ready", in_ready, 1);
      reset = 1'b0;
      #1;
      check_all_zero("mid_rst");
      tick();
      tick();
      reset = 1'b1;
      #1;
      tick();
      chk("mid_no_frame_ready_a", frame_ready, 0);
      chk("mid_flushed_a", blend_pixel_ready, 0);
      tick();
      chk("mid_no_frame_ready_b", frame_ready, 0);
      chk("mid_flushed_b", blend_pixel_ready, 0);
      frag(17'd30, 8'h12, 8'h34, 8'h56, 8'h78, 1'b1);
      tick();
      in_valid = 1'b0;
      tick();
      chk("mid_new_bpr", blend_pixel_ready, 1);
      chk("mid_new_bpn", blend_pixel_number, 30);
      chk("mid_new_rgba", {blend_r, blend_g, blend_b, blend_a}, 32'h12345678);
      tick();
      retire(17'd30);
      tick();
      blend_write = 1'b0;
      chk("mid_new_frame_ready", frame_ready, 1);
      chk("mid_new_no_err", order_error, 0);
      tick();
      chk("mid_new_fr_off", frame_ready, 0);
      chk("mid_new_idle", busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/blend_scheduler.md
# blend_scheduler

Front-end scheduler for the alpha-blend datapath. Accepts RGBA fragments from the rasterizer over a valid/ready handshake, buffers them in a small FIFO, and issues them one per cycle to the alpha blender as `pixel_ready` pulses. It keeps an in-order scoreboard of in-flight pixel addresses, so two fragments to the same pixel never overlap in the read-modify-write pipe. It signals frame completion once the last fragment of a frame has retired.

## Interface
- DEPTH, 4, fragment FIFO entries (power of 2, ≥2)
- MAX_INFLIGHT, 2, max fragments issued but not yet retired by the blender (1..4)
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  rasterizer fragment valid
- in_ready  out  1  scheduler can accept a fragment this cycle
- in_pixel_number  in  17  frame-buffer pixel address
- in_r, in_g, in_b, in_a  in  8 each  source colour and alpha
- in_last  in  1  fragment is the last of the frame
- blend_pixel_ready  out  1  one-cycle issue strobe to blender
- blend_pixel_number  out  17  issued pixel address (registered)
- blend_r, blend_g, blend_b, blend_a  out  8 each  issued colour/alpha (registered)
- blend_write  in  1  blender retire strobe, one per issued fragment, in issue order
- blend_pixel_number_o  in  17  address of the retiring fragment
- frame_ready  out  1  one-cycle pulse: whole frame retired
- busy  out  1  state ≠ IDLE
- order_error  out  1  sticky: bad retire seen

## Operation
- **Handshake:** a fragment is accepted on an edge where `in_valid && in_ready`.
  - `in_ready = !fifo_full && state ∈ {IDLE, RUN}`.
  - Each FIFO entry holds 50 bits: address, r, g, b, a, last.
- **Issue condition** (evaluated every cycle on pre-edge state):
  - FIFO not empty, and
  - inflight_count < MAX_INFLIGHT, and
  - head address does not equal any valid scoreboard entry.
- **On issue:**
  - Pop the FIFO head.
  - Register the head fields onto the `blend_*` outputs.
  - Pulse `blend_pixel_ready` for one cycle.
  - Push the address onto the scoreboard tail.
  - At most one issue per cycle; back-to-back issues are allowed.
- **Scoreboard:** in-order queue of MAX_INFLIGHT addresses with valid bits.
  - `blend_write` pops the oldest entry.
  - If `blend_pixel_number_o` ≠ oldest address, or the scoreboard is empty, set `order_error`.
  - When the scoreboard is empty, `blend_write` is otherwise ignored.
  - `order_error` stays set until reset.
- **Simultaneous issue and retire:** both take effect and the count is unchanged. The hazard check uses pre-retire contents, so a fragment whose address matches the retiring entry stalls one extra cycle.
- **Simultaneous accept and issue:** the FIFO count is unchanged. An empty FIFO cannot issue a fragment in the cycle it is accepted; there is no bypass.
- **FSM:**
  - IDLE: an accepted fragment moves to RUN. If that fragment has `in_last`, go directly to DRAIN.
  - RUN: an accepted fragment with `in_last` moves to DRAIN.
  - DRAIN: no further accepts. When the FIFO is empty and inflight_count = 0, move to DONE.
  - DONE: assert `frame_ready` for one cycle, then go to IDLE unconditionally.
- **Frame boundary:** fragments of the next frame wait at the `in_ready` boundary until the FSM returns to IDLE.
- **Data path:** no arithmetic on colour data; values pass through bit-exact.

## Timing
- **Reset (asserted, async):**
  - All outputs 0: `in_ready`, `blend_pixel_ready`, `blend_*` data, `frame_ready`, `busy`, `order_error`.
  - FIFO and scoreboard flushed; state = IDLE.
  - The first cycle after release has `in_ready = 1`.
- **Reset mid-frame:** all buffered and in-flight fragments are discarded and no `frame_ready` is produced. Blender strobes arriving after release with an empty scoreboard set `order_error`; the bench must not drive them.
- **Latency:** a fragment accepted at edge N into an empty, unhazarded scheduler appears with `blend_pixel_ready = 1` in the cycle following edge N+1 (one-cycle FIFO residency plus registered output).
- **`blend_*` data outputs:** hold their last issued value between issues.
- **`frame_ready`:** high for exactly the cycle after the edge at which the DRAIN exit condition is met. That edge is the one sampling the final `blend_write` when the FIFO is already empty.
- **`in_ready` when full:** the deassertion is visible in the same cycle the FIFO becomes full. Throughput while the pipe is unobstructed is one fragment per cycle.

## Test plan
- **Reset:** hold `reset = 0` for 2 cycles, then release. All outputs are 0 during reset; the next cycle shows `in_ready = 1`, `busy = 0`.
- **Single-fragment frame:** address 5, rgba = 80/40/C0/11, `in_last = 1`.
  - `blend_pixel_ready` pulses one cycle with those values.
  - Drive `blend_write` with number 5 two cycles later.
  - `frame_ready` pulses for one cycle, then `busy = 0`.
- **RAW hazard:** back-to-back fragments to address 7, then address 8.
  - The first 7 issues immediately.
  - The second 7 does not issue until the cycle after the first 7's `blend_write` is sampled.
  - Address 8, queued behind it, follows on the next cycle.
- **Full/backpressure:** DEPTH = 4, MAX_INFLIGHT = 2, no `blend_write`.
  - Exactly 6 fragments (distinct addresses) are accepted and 2 issued; `in_ready` stays 0.
  - One retire then frees a slot: a third issue follows, and one more fragment is accepted.
- **Order error:** issue address 3, retire with `blend_pixel_number_o = 4`. `order_error` rises and stays 1 until reset; `blend_write` with an empty scoreboard also sets it.
- **Reset mid-frame:** 3 fragments queued, 2 in flight, then assert reset. All state clears, no `frame_ready` occurs, and a new frame completes normally afterward.
